// File: rtl/instruction_loader.sv
// Instruction loader: captures a valid/data/address/done stream into instruction RAM, holds the CPU in reset until loaded, then serves fetches.
// Optional running checksum of accepted words is built when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [31:0]           in_addr,
   input  logic                  in_done,
   input  logic                  reload,
   input  logic                  fetch_en,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic [DATA_WIDTH-1:0] fetch_data,
   output logic                  fetch_valid,
   output logic                  program_ready,
   output logic                  cpu_rst,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  err_range,
   output logic                  err_order,
   output logic [DATA_WIDTH-1:0] checksum
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic {LOAD, READY} state_t;

   state_t                state_reg, state_next;
   logic                  done_q;
   logic                  done_rise;
   logic                  in_range;
   logic                  accept;
   logic                  reject;
   logic                  go_ready;
   logic                  go_load;
   logic [ADDR_WIDTH:0]   expected;
   logic [31:0]           expected_ext;
   logic [DATA_WIDTH-1:0] ram [DEPTH];

   assign done_rise    = in_done & ~done_q;
   assign in_range     = (in_addr[31:ADDR_WIDTH] == '0);
   assign accept       = (state_reg == LOAD) && in_valid && in_range;
   assign reject       = (state_reg == LOAD) && in_valid && !in_range;
   assign expected_ext = 32'(expected);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= LOAD;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      go_ready   = 1'b0;
      go_load    = 1'b0;
      case (state_reg)
         LOAD: begin
            if (done_rise) begin
               state_next = READY;
               go_ready   = 1'b1;
            end
         end
         READY: begin
            if (reload) begin
               state_next = LOAD;
               go_load    = 1'b1;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q        <= 1'b0;
         program_ready <= 1'b0;
         cpu_rst       <= 1'b1;
         word_count    <= '0;
         expected      <= '0;
         err_range     <= 1'b0;
         err_order     <= 1'b0;
      end else begin
         done_q <= in_done;
         if (go_load) begin
            program_ready <= 1'b0;
            cpu_rst       <= 1'b1;
            word_count    <= '0;
            expected      <= '0;
            err_range     <= 1'b0;
            err_order     <= 1'b0;
         end else begin
            if (accept) begin
               if (word_count != FULL_COUNT) word_count <= word_count + ONE;
               expected <= {1'b0, in_addr[ADDR_WIDTH-1:0]} + ONE;
               if (in_addr != expected_ext) err_order <= 1'b1;
            end
            if (reject) err_range <= 1'b1;
            if (go_ready) begin
               program_ready <= 1'b1;
               cpu_rst       <= 1'b0;
            end
         end
      end
   end

   // RAM contents survive reset; only the write and read ports are clocked here.
   always_ff @(posedge clk) begin
      if (accept) ram[in_addr[ADDR_WIDTH-1:0]] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_data  <= '0;
         fetch_valid <= 1'b0;
      end else begin
         fetch_valid <= (state_reg == READY) && fetch_en;
         if ((state_reg == READY) && fetch_en) fetch_data <= ram[fetch_addr];
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          checksum_reg <= '0;
      else if (go_load) checksum_reg <= '0;
      else if (accept)  checksum_reg <= checksum_reg + in_data;
   end

   assign checksum = checksum_reg;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios plus randomized loads against a behavioural model.
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic [31:0] in_addr;
   logic        in_done;
   logic        reload;
   logic        fetch_en;
   logic [5:0]  fetch_addr;
   logic [31:0] fetch_data;
   logic        fetch_valid;
   logic        program_ready;
   logic        cpu_rst;
   logic [6:0]  word_count;
   logic        err_range;
   logic        err_order;
   logic [31:0] checksum;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   bit          m_ready, m_done_q, m_fvalid, m_err_r, m_err_o;
   int          m_count, m_exp;
   logic [31:0] m_fdata, m_csum;
   logic [31:0] m_ram [64];

   always #5 clk = ~clk;

   instruction_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
      .in_done(in_done), .reload(reload), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
      .fetch_data(fetch_data), .fetch_valid(fetch_valid), .program_ready(program_ready),
      .cpu_rst(cpu_rst), .word_count(word_count), .err_range(err_range),
      .err_order(err_order), .checksum(checksum)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ready = 0; m_done_q = 0; m_fvalid = 0; m_err_r = 0; m_err_o = 0;
      m_count = 0; m_exp = 0; m_fdata = 0; m_csum = 0;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] cs_exp;
`ifdef LOADER_CHECKSUM_EN
      cs_exp = m_csum;
`else
      cs_exp = 32'd0;
`endif
      chk({tag, ".ready"}, 32'(program_ready), 32'(m_ready));
      chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(!m_ready));
      chk({tag, ".fvalid"}, 32'(fetch_valid), 32'(m_fvalid));
      chk({tag, ".fdata"}, fetch_data, m_fdata);
      chk({tag, ".count"}, 32'(word_count), 32'(m_count));
      chk({tag, ".err_range"}, 32'(err_range), 32'(m_err_r));
      chk({tag, ".err_order"}, 32'(err_order), 32'(m_err_o));
      chk({tag, ".checksum"}, checksum, cs_exp);
      $display("[%0t] %s v=%0b a=%0d d=%h done=%0b rl=%0b fe=%0b fa=%0d | rdy=%0b cnt=%0d er=%0b eo=%0b fv=%0b fd=%h",
               $time, tag, in_valid, in_addr, in_data, in_done, reload, fetch_en, fetch_addr,
               program_ready, word_count, err_range, err_order, fetch_valid, fetch_data);
   endtask

   // One clock: drive inputs, advance model by the spec's rules, check after the edge.
   task automatic step(input string tag, input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic dn, input logic rl, input logic fe, input logic [5:0] fa);
      bit rise;
      in_valid = v; in_addr = a; in_data = d; in_done = dn; reload = rl;
      fetch_en = fe; fetch_addr = fa;
      @(posedge clk);
      rise = dn && !m_done_q;
      if (m_ready && fe) begin
         m_fvalid = 1;
         m_fdata  = m_ram[fa];
      end else begin
         m_fvalid = 0;
      end
      if (!m_ready) begin
         if (v) begin
            if (a < 64) begin
               m_ram[a] = d;
               if (m_count < 64) m_count++;
               if (a != 32'(m_exp)) m_err_o = 1;
               m_exp  = int'(a) + 1;
               m_csum = m_csum + d;
            end else begin
               m_err_r = 1;
            end
         end
         if (rise) m_ready = 1;
      end else if (rl) begin
         m_ready = 0; m_count = 0; m_exp = 0; m_err_r = 0; m_err_o = 0; m_csum = 0;
      end
      m_done_q = dn;
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input logic dn);
      step(tag, 0, 0, 0, dn, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] cs6;
      int          n;
      logic [31:0] a;
      rst = 1; in_valid = 0; in_data = 0; in_addr = 0; in_done = 0; reload = 0;
      fetch_en = 0; fetch_addr = 0;
      model_reset();
      for (int i = 0; i < 64; i++) m_ram[i] = 'x;
      #12;
      check_all("reset");
      @(negedge clk); rst = 0;

      // Scenario 1: 28 sequential words then done rises
      for (int i = 0; i < 28; i++) step("t1_load", 1, i, 32'h100 + i, 0, 0, 0, 0);
      idle("t1_done", 1);
      chk("t1_count28", 32'(word_count), 32'd28);
      chk("t1_ready", 32'(program_ready), 32'd1);
      step("t1_fetch5", 0, 0, 0, 1, 0, 1, 6'd5);
      chk("t1_fdata", fetch_data, 32'h105);
      idle("t1_nofetch", 1);

      // Scenario 5b: reload with done held high stays in LOAD until done re-rises
      step("t5_reload", 0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) idle("t5_held", 1);
      chk("t5_still_load", 32'(program_ready), 32'd0);
      step("t5_fetch_in_load", 0, 0, 0, 1, 0, 1, 6'd5);
      chk("t5_fdata_hold", fetch_data, 32'h105);
      idle("t5_low", 0);

      // Scenario 2: out-of-range address
      step("t2_range", 1, 70, 32'hDEAD_BEEF, 0, 0, 0, 0);
      chk("t2_err_range", 32'(err_range), 32'd1);
      chk("t2_count0", 32'(word_count), 32'd0);
      idle("t2_done", 1);
      step("t2_fetch6", 0, 0, 0, 1, 0, 1, 6'd6);
      chk("t2_ram6_kept", fetch_data, 32'h106);
      step("t2_reload", 0, 0, 0, 1, 1, 0, 0);
      idle("t2_low", 0);

      // Scenario 3: out-of-order address 0,1,3
      step("t3_a0", 1, 0, 32'hA0, 0, 0, 0, 0);
      step("t3_a1", 1, 1, 32'hA1, 0, 0, 0, 0);
      chk("t3_no_err_yet", 32'(err_order), 32'd0);
      step("t3_a3", 1, 3, 32'hA3, 0, 0, 0, 0);
      chk("t3_err_order", 32'(err_order), 32'd1);
      chk("t3_count3", 32'(word_count), 32'd3);
      idle("t3_done", 1);
      step("t3_fetch3", 0, 0, 0, 1, 0, 1, 6'd3);
      chk("t3_ram3", fetch_data, 32'hA3);
      step("t3_reload", 0, 0, 0, 1, 1, 0, 0);
      idle("t3_low", 0);

      // Scenario 4: last word coincides with done rise
      for (int i = 0; i < 27; i++) step("t4_load", 1, i, 32'h400 + i, 0, 0, 0, 0);
      step("t4_last_done", 1, 27, 32'h41B, 1, 0, 0, 0);
      chk("t4_count28", 32'(word_count), 32'd28);
      chk("t4_ready", 32'(program_ready), 32'd1);
      step("t4_fetch27", 0, 0, 0, 1, 0, 1, 6'd27);
      chk("t4_ram27", fetch_data, 32'h41B);
      step("t4_reload", 0, 0, 0, 1, 1, 0, 0);
      idle("t4_low", 0);

      // Scenario 5a: async reset after 10 words
      for (int i = 0; i < 10; i++) step("t5_load", 1, i, 32'h500 + i, 0, 0, 0, 0);
      #2; rst = 1; #1;
      model_reset();
      check_all("t5_rst");
      chk("t5_rst_count", 32'(word_count), 32'd0);
      @(negedge clk); rst = 0;

      // Scenario 6: checksum over 1,2,3 plus a rejected 9
      step("t6_w1", 1, 0, 1, 0, 0, 0, 0);
      step("t6_w2", 1, 1, 2, 0, 0, 0, 0);
      step("t6_w3", 1, 2, 3, 0, 0, 0, 0);
      step("t6_w9", 1, 99, 9, 0, 0, 0, 0);
`ifdef LOADER_CHECKSUM_EN
      cs6 = 32'd6;
`else
      cs6 = 32'd0;
`endif
      chk("t6_checksum", checksum, cs6);
      idle("t6_done", 1);
      step("t6_reload", 0, 0, 0, 1, 1, 0, 0);
      idle("t6_low", 0);

      // Fill all 64 words (plus rewrites to exercise saturation), then randomized rounds
      for (int i = 0; i < 64; i++) step("fill", 1, i, $urandom, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("fill_sat", 1, $urandom_range(0, 63), $urandom, 0, 0, 0, 0);
      chk("fill_sat64", 32'(word_count), 32'd64);
      idle("fill_done", 1);
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++)
            step("rnd_fetch", 0, 0, 0, 1, 0, 1'($urandom), 6'($urandom));
         step("rnd_reload", 0, 0, 0, 1, 1, 0, 0);
         idle("rnd_low", 0);
         n = $urandom_range(5, 40);
         a = 0;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 80);
            step("rnd_load", 1'($urandom_range(0, 4) != 0), a, $urandom, 0, 0,
                 1'($urandom), 6'($urandom));
            a = a + 1;
         end
         step("rnd_done", 1'($urandom), a, $urandom, 1, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
